// File: rtl/fir_stream_ctrl.sv
// Run controller for a 9-tap FIR datapath: holds the coefficient bank, buffers
// incoming samples and streams a programmed number of them into the filter.
module fir_stream_ctrl #(
  parameter int DW         = 12,
  parameter int NTAP       = 9,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CFG_WE,
  input  logic [3:0]       CFG_ADDR,
  input  logic [DW-1:0]    CFG_DATA,
  output logic             CFG_ERR,
  input  logic             START,
  input  logic [CNT_W-1:0] N_SAMPLES,
  input  logic [DW-1:0]    S_DATA,
  input  logic             S_VALID,
  output logic             S_READY,
  output logic [DW-1:0]    DIN,
  output logic             VIN,
  output logic [DW-1:0]    H0,
  output logic [DW-1:0]    H1,
  output logic [DW-1:0]    H2,
  output logic [DW-1:0]    H3,
  output logic [DW-1:0]    H4,
  output logic [DW-1:0]    H5,
  output logic [DW-1:0]    H6,
  output logic [DW-1:0]    H7,
  output logic [DW-1:0]    H8,
  input  logic             VOUT_FIR,
  output logic             BUSY,
  output logic             DONE
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] N_ONE    = CNT_W'(1);
  localparam logic [3:0]       NTAP_A   = 4'(NTAP);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t           state_q;
  logic [DW-1:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic [DW-1:0]    coef_q [NTAP];
  logic [CNT_W-1:0] n_q, issued_q, recvd_q;
  logic [DW-1:0]    din_q;
  logic             vin_q, busy_q, done_q, cfg_err_q;
  logic             push, pop, full, empty, in_run_window;

  assign full          = (count_q == FULL_CNT);
  assign empty         = (count_q == '0);
  // Held low during reset so the source cannot push into a FIFO being flushed.
  assign S_READY       = RST_N && !full;
  assign push          = S_VALID && S_READY;
  assign pop           = (state_q == RUN) && !empty;
  assign in_run_window = (state_q == RUN) || (state_q == DRAIN);

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_q] <= S_DATA;
  end

  // Coefficients may only change in IDLE, so they stay frozen for a whole run.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      n_q       <= '0;
      issued_q  <= '0;
      recvd_q   <= '0;
      din_q     <= '0;
      vin_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      for (int k = 0; k < NTAP; k++) coef_q[k] <= '0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      vin_q     <= 1'b0;

      if (CFG_WE) begin
        if ((state_q == IDLE) && (CFG_ADDR < NTAP_A)) coef_q[CFG_ADDR] <= CFG_DATA;
        else cfg_err_q <= 1'b1;
      end

      if (pop) begin
        din_q    <= fifo_mem[rd_ptr_q];
        vin_q    <= 1'b1;
        issued_q <= issued_q + N_ONE;
      end

      if (VOUT_FIR && in_run_window && (recvd_q != n_q)) recvd_q <= recvd_q + N_ONE;

      case (state_q)
        IDLE: begin
          if (START) begin
            if (N_SAMPLES != '0) begin
              n_q      <= N_SAMPLES;
              issued_q <= '0;
              recvd_q  <= '0;
              busy_q   <= 1'b1;
              state_q  <= RUN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (pop && (issued_q == n_q - N_ONE)) state_q <= DRAIN;
        end
        DRAIN: begin
          if (recvd_q == n_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign DIN     = din_q;
  assign VIN     = vin_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign CFG_ERR = cfg_err_q;
  assign H0 = coef_q[0];
  assign H1 = coef_q[1];
  assign H2 = coef_q[2];
  assign H3 = coef_q[3];
  assign H4 = coef_q[4];
  assign H5 = coef_q[5];
  assign H6 = coef_q[6];
  assign H7 = coef_q[7];
  assign H8 = coef_q[8];

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Bench for fir_stream_ctrl: a queue-based sample model plus a fixed-latency
// filter stand-in that echoes every VIN as a VOUT_FIR pulse three cycles later.
module tb_fir_stream_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CFG_WE = 1'b0;
  logic [3:0]  CFG_ADDR = '0;
  logic [11:0] CFG_DATA = '0;
  logic        CFG_ERR;
  logic        START = 1'b0;
  logic [15:0] N_SAMPLES = '0;
  logic [11:0] S_DATA = '0;
  logic        S_VALID = 1'b0;
  logic        S_READY;
  logic [11:0] DIN;
  logic        VIN;
  logic [11:0] H0, H1, H2, H3, H4, H5, H6, H7, H8;
  logic        VOUT_FIR = 1'b0;
  logic        BUSY;
  logic        DONE;

  int checks = 0;
  int failures = 0;
  int doneSeen = 0;
  logic [11:0] modelQ[$];
  logic [11:0] obsDin[$];
  logic [11:0] modelH [9];
  logic [7:0]  vinHist = '0;

  fir_stream_ctrl dut (
    .CLK(CLK), .RST_N(RST_N),
    .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA), .CFG_ERR(CFG_ERR),
    .START(START), .N_SAMPLES(N_SAMPLES),
    .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
    .DIN(DIN), .VIN(VIN),
    .H0(H0), .H1(H1), .H2(H2), .H3(H3), .H4(H4), .H5(H5), .H6(H6), .H7(H7), .H8(H8),
    .VOUT_FIR(VOUT_FIR), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  function automatic logic [11:0] getH(input int k);
    case (k)
      0: return H0;
      1: return H1;
      2: return H2;
      3: return H3;
      4: return H4;
      5: return H5;
      6: return H6;
      7: return H7;
      default: return H8;
    endcase
  endfunction

  // One clock: update the model from what the edge will see, then observe outputs.
  task automatic step();
    bit pushNow;
    bit rstNow;
    logic [11:0] dataNow;
    pushNow = S_VALID && S_READY;
    rstNow  = RST_N;
    dataNow = S_DATA;
    @(posedge CLK);
    #1;
    if (!rstNow) begin
      modelQ.delete();
      for (int k = 0; k < 9; k++) modelH[k] = '0;
    end else if (pushNow) begin
      modelQ.push_back(dataNow);
    end
    if (VIN === 1'b1) obsDin.push_back(DIN);
    if (DONE === 1'b1) doneSeen++;
    vinHist = {vinHist[6:0], (VIN === 1'b1)};
    VOUT_FIR = vinHist[3];
  endtask

  task automatic waitDone(input int budget, output bit ok);
    int n;
    n = 0;
    while (doneSeen < 1 && n < budget) begin
      step();
      n++;
    end
    ok = (doneSeen >= 1);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    step();
    step();
    checks++; if (S_READY !== 1'b0) begin failures++; $display("[TB] FAIL reset_sready: got %b expected 0", S_READY); end
    checks++; if (VIN !== 1'b0) begin failures++; $display("[TB] FAIL reset_vin: got %b expected 0", VIN); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", DONE); end
    checks++; if (CFG_ERR !== 1'b0) begin failures++; $display("[TB] FAIL reset_cfg_err: got %b expected 0", CFG_ERR); end
    checks++; if (DIN !== 12'h000) begin failures++; $display("[TB] FAIL reset_din: got %h expected 000", DIN); end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (getH(k) !== 12'h000) begin failures++; $display("[TB] FAIL reset_h%0d: got %h expected 000", k, getH(k)); end
    end
    RST_N = 1'b1;
    step();
    checks++; if (S_READY !== 1'b1) begin failures++; $display("[TB] FAIL reset_release_sready: got %b expected 1", S_READY); end
  endtask

  task automatic test_config();
    logic [11:0] val;
    for (int k = 0; k < 9; k++) begin
      val = 12'(k + 1);
      CFG_WE = 1'b1; CFG_ADDR = 4'(k); CFG_DATA = val;
      step();
      CFG_WE = 1'b0;
      modelH[k] = val;
      checks++;
      if (getH(k) !== modelH[k]) begin failures++; $display("[TB] FAIL cfg_write_h%0d: got %h expected %h", k, getH(k), modelH[k]); end
      checks++;
      if (CFG_ERR !== 1'b0) begin failures++; $display("[TB] FAIL cfg_write_err%0d: got %b expected 0", k, CFG_ERR); end
    end
    for (int j = 0; j < 2; j++) begin
      CFG_WE = 1'b1;
      CFG_ADDR = (j == 0) ? 4'd9 : 4'($urandom_range(10, 15));
      CFG_DATA = 12'($urandom);
      step();
      CFG_WE = 1'b0;
      checks++;
      if (CFG_ERR !== 1'b1) begin failures++; $display("[TB] FAIL cfg_bad_addr_err: got %b expected 1", CFG_ERR); end
      step();
      checks++;
      if (CFG_ERR !== 1'b0) begin failures++; $display("[TB] FAIL cfg_bad_addr_pulse: got %b expected 0", CFG_ERR); end
      for (int k = 0; k < 9; k++) begin
        checks++;
        if (getH(k) !== modelH[k]) begin failures++; $display("[TB] FAIL cfg_bad_addr_h%0d: got %h expected %h", k, getH(k), modelH[k]); end
      end
    end
  endtask

  task automatic test_prefill_run();
    bit ok;
    logic [11:0] exp;
    obsDin.delete();
    doneSeen = 0;
    for (int i = 0; i < 8; i++) begin
      S_VALID = 1'b1; S_DATA = 12'($urandom);
      step();
    end
    S_VALID = 1'b0;
    checks++; if (S_READY !== 1'b0) begin failures++; $display("[TB] FAIL prefill_full: got %b expected 0", S_READY); end
    START = 1'b1; N_SAMPLES = 16'd8;
    step();
    START = 1'b0;
    checks++; if (BUSY !== 1'b1) begin failures++; $display("[TB] FAIL prefill_busy: got %b expected 1", BUSY); end
    checks++; if (VIN !== 1'b0) begin failures++; $display("[TB] FAIL prefill_vin_t1: got %b expected 0", VIN); end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (VIN !== 1'b1) begin failures++; $display("[TB] FAIL prefill_vin_%0d: got %b expected 1", i, VIN); end
    end
    step();
    checks++; if (VIN !== 1'b0) begin failures++; $display("[TB] FAIL prefill_vin_after: got %b expected 0", VIN); end
    waitDone(60, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL prefill_done_timeout: got no DONE expected DONE within 60 cycles"); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("[TB] FAIL prefill_busy_fall: got %b expected 0", BUSY); end
    step();
    checks++; if (DONE !== 1'b0) begin failures++; $display("[TB] FAIL prefill_done_pulse: got %b expected 0", DONE); end
    checks++; if (obsDin.size() != 8) begin failures++; $display("[TB] FAIL prefill_count: got %0d expected 8", obsDin.size()); end
    for (int i = 0; i < 8 && i < obsDin.size(); i++) begin
      exp = modelQ.pop_front();
      checks++;
      if (obsDin[i] !== exp) begin failures++; $display("[TB] FAIL prefill_din_%0d: got %h expected %h", i, obsDin[i], exp); end
    end
  endtask

  task automatic test_gapped_source();
    bit ok;
    logic [11:0] exp;
    obsDin.delete();
    doneSeen = 0;
    START = 1'b1; N_SAMPLES = 16'd4;
    step();
    START = 1'b0;
    for (int i = 0; i < 5; i++) begin
      S_VALID = 1'b1; S_DATA = 12'($urandom);
      step();
      S_VALID = 1'b0;
      checks++;
      if (VIN !== 1'b0) begin failures++; $display("[TB] FAIL gap_push_vin_%0d: got %b expected 0", i, VIN); end
      step();
      checks++;
      if (VIN !== (i < 4)) begin failures++; $display("[TB] FAIL gap_pop_vin_%0d: got %b expected %b", i, VIN, (i < 4)); end
      step();
    end
    waitDone(40, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL gap_done_timeout: got no DONE expected DONE within 40 cycles"); end
    checks++; if (obsDin.size() != 4) begin failures++; $display("[TB] FAIL gap_count: got %0d expected 4", obsDin.size()); end
    for (int i = 0; i < 4 && i < obsDin.size(); i++) begin
      exp = modelQ.pop_front();
      checks++;
      if (obsDin[i] !== exp) begin failures++; $display("[TB] FAIL gap_din_%0d: got %h expected %h", i, obsDin[i], exp); end
    end
  endtask

  task automatic test_run_errors();
    bit ok;
    logic [11:0] exp;
    obsDin.delete();
    doneSeen = 0;
    for (int i = 0; i < 3; i++) begin
      S_VALID = 1'b1; S_DATA = 12'($urandom);
      step();
    end
    S_VALID = 1'b0;
    START = 1'b1; N_SAMPLES = 16'd4;
    step();
    START = 1'b0;
    CFG_WE = 1'b1; CFG_ADDR = 4'd0; CFG_DATA = ~modelH[0];
    step();
    CFG_WE = 1'b0;
    checks++; if (CFG_ERR !== 1'b1) begin failures++; $display("[TB] FAIL run_cfg_err: got %b expected 1", CFG_ERR); end
    checks++; if (H0 !== modelH[0]) begin failures++; $display("[TB] FAIL run_cfg_h0: got %h expected %h", H0, modelH[0]); end
    START = 1'b1; N_SAMPLES = 16'd2;
    step();
    START = 1'b0;
    checks++; if (BUSY !== 1'b1) begin failures++; $display("[TB] FAIL run_start_busy: got %b expected 1", BUSY); end
    waitDone(40, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL run_done_timeout: got no DONE expected DONE within 40 cycles"); end
    for (int i = 0; i < 10; i++) step();
    checks++; if (doneSeen != 1) begin failures++; $display("[TB] FAIL run_done_count: got %0d expected 1", doneSeen); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("[TB] FAIL run_busy_end: got %b expected 0", BUSY); end
    checks++; if (obsDin.size() != 4) begin failures++; $display("[TB] FAIL run_count: got %0d expected 4", obsDin.size()); end
    for (int i = 0; i < 4 && i < obsDin.size(); i++) begin
      exp = modelQ.pop_front();
      checks++;
      if (obsDin[i] !== exp) begin failures++; $display("[TB] FAIL run_din_%0d: got %h expected %h", i, obsDin[i], exp); end
    end
  endtask

  task automatic test_midrun_reset();
    bit ok;
    logic [11:0] exp;
    obsDin.delete();
    doneSeen = 0;
    for (int i = 0; i < 8; i++) begin
      S_VALID = 1'b1; S_DATA = 12'($urandom);
      step();
    end
    S_VALID = 1'b0;
    START = 1'b1; N_SAMPLES = 16'd8;
    step();
    START = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++; if (obsDin.size() != 3) begin failures++; $display("[TB] FAIL mid_issued: got %0d expected 3", obsDin.size()); end
    RST_N = 1'b0;
    step();
    checks++; if (VIN !== 1'b0) begin failures++; $display("[TB] FAIL mid_vin: got %b expected 0", VIN); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("[TB] FAIL mid_busy: got %b expected 0", BUSY); end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (getH(k) !== modelH[k]) begin failures++; $display("[TB] FAIL mid_h%0d: got %h expected %h", k, getH(k), modelH[k]); end
    end
    RST_N = 1'b1;
    step();
    checks++; if (S_READY !== 1'b1) begin failures++; $display("[TB] FAIL mid_sready: got %b expected 1", S_READY); end
    for (int i = 0; i < 12; i++) step();
    checks++; if (doneSeen != 0) begin failures++; $display("[TB] FAIL mid_no_done: got %0d expected 0", doneSeen); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("[TB] FAIL mid_busy_idle: got %b expected 0", BUSY); end
    obsDin.delete();
    S_VALID = 1'b1; S_DATA = 12'($urandom);
    step();
    S_VALID = 1'b0;
    START = 1'b1; N_SAMPLES = 16'd1;
    step();
    START = 1'b0;
    waitDone(30, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL mid_rerun_timeout: got no DONE expected DONE within 30 cycles"); end
    checks++; if (obsDin.size() != 1) begin failures++; $display("[TB] FAIL mid_rerun_count: got %0d expected 1", obsDin.size()); end
    if (obsDin.size() > 0) begin
      exp = modelQ.pop_front();
      checks++;
      if (obsDin[0] !== exp) begin failures++; $display("[TB] FAIL mid_rerun_din: got %h expected %h", obsDin[0], exp); end
    end
  endtask

  task automatic test_zero_run();
    obsDin.delete();
    doneSeen = 0;
    for (int i = 0; i < 2; i++) begin
      S_VALID = 1'b1; S_DATA = 12'($urandom);
      step();
    end
    S_VALID = 1'b0;
    START = 1'b1; N_SAMPLES = 16'd0;
    step();
    START = 1'b0;
    checks++; if (DONE !== 1'b1) begin failures++; $display("[TB] FAIL zero_done: got %b expected 1", DONE); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("[TB] FAIL zero_busy: got %b expected 0", BUSY); end
    step();
    checks++; if (DONE !== 1'b0) begin failures++; $display("[TB] FAIL zero_done_pulse: got %b expected 0", DONE); end
    for (int i = 0; i < 5; i++) step();
    checks++; if (obsDin.size() != 0) begin failures++; $display("[TB] FAIL zero_no_vin: got %0d expected 0", obsDin.size()); end
    checks++; if (doneSeen != 1) begin failures++; $display("[TB] FAIL zero_done_count: got %0d expected 1", doneSeen); end
  endtask

  task automatic test_random_runs();
    bit ok;
    int n;
    int cyc;
    logic [3:0] addr;
    logic [11:0] exp;
    for (int r = 0; r < 6; r++) begin
      addr = 4'($urandom_range(0, 15));
      CFG_WE = 1'b1; CFG_ADDR = addr; CFG_DATA = 12'($urandom);
      if (addr < 9) modelH[addr] = CFG_DATA;
      step();
      CFG_WE = 1'b0;
      checks++;
      if (CFG_ERR !== (addr >= 9)) begin failures++; $display("[TB] FAIL rand_cfg_err_%0d: got %b expected %b", r, CFG_ERR, (addr >= 9)); end
      for (int k = 0; k < 9; k++) begin
        checks++;
        if (getH(k) !== modelH[k]) begin failures++; $display("[TB] FAIL rand_h%0d_run%0d: got %h expected %h", k, r, getH(k), modelH[k]); end
      end
      n = $urandom_range(1, 12);
      obsDin.delete();
      doneSeen = 0;
      START = 1'b1; N_SAMPLES = 16'(n);
      step();
      START = 1'b0;
      cyc = 0;
      while (doneSeen < 1 && cyc < 300) begin
        S_VALID = (modelQ.size() < n) ? 1'($urandom_range(0, 1)) : 1'b0;
        S_DATA = 12'($urandom);
        step();
        cyc++;
      end
      S_VALID = 1'b0;
      ok = (doneSeen >= 1);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL rand_done_timeout_%0d: got no DONE expected DONE within 300 cycles", r); end
      checks++; if (BUSY !== 1'b0) begin failures++; $display("[TB] FAIL rand_busy_%0d: got %b expected 0", r, BUSY); end
      checks++; if (obsDin.size() != n) begin failures++; $display("[TB] FAIL rand_count_%0d: got %0d expected %0d", r, obsDin.size(), n); end
      for (int i = 0; i < n && i < obsDin.size(); i++) begin
        exp = modelQ.pop_front();
        checks++;
        if (obsDin[i] !== exp) begin failures++; $display("[TB] FAIL rand_din_%0d_%0d: got %h expected %h", r, i, obsDin[i], exp); end
      end
      step();
    end
  endtask

  initial begin
    for (int k = 0; k < 9; k++) modelH[k] = '0;
    test_reset();
    test_config();
    test_prefill_run();
    test_gapped_source();
    test_run_errors();
    test_midrun_reset();
    test_zero_run();
    test_random_runs();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
